i2c_sensor_cfg_seq: RTL and testbench
=====================================

# i2c_sensor_cfg_seq

Parametrised I2C register-configuration sequencer for image sensors. After reset it walks an external register table of LUT_SIZE entries, issuing one `{slave, register, data}` write per entry to the I2C byte engine through a GO/END/NACK handshake. It retries NACKed writes and reports per-entry errors. Once the table completes, it accepts live exposure-register updates without replaying the table. It sits between the camera top level (exposure keys, status LEDs) and the I2C bit engine.

## Interface
Parameters:
- CLK_DIV, 2500 — iCLK cycles per control tick; the FSM advances only on ticks; legal range ≥ 2
- SLAVE_ADDR, 8'hBA — 8-bit write address placed in every frame
- DATA_W, 16 — register data width; legal values 8 or 16
- LUT_SIZE, 17 — number of table entries; legal range 1..255
- MAX_TRY, 3 — attempts per write before the write is declared failed; legal range 1..15
- EXP_REG, 8'h09 — register address used for live exposure writes

Ports:
- iCLK  in  1  system clock
- iRST  in  1  synchronous, active-high reset
- oLUT_ADDR  out  8  table index, registered
- iLUT_DATA  in  8+DATA_W  `{reg[7:0], data}`; must be valid one iCLK after oLUT_ADDR changes
- oI2C_DATA  out  16+DATA_W  `{SLAVE_ADDR, reg, data}` frame to the I2C engine
- oGO  out  1  write request, level
- iEND  in  1  engine transfer complete, level
- iNACK  in  1  engine saw NACK; sampled with iEND
- iRESTART  in  1  one-cycle pulse; replays the whole table
- iEXP_VALUE  in  DATA_W  exposure value
- iEXP_UPDATE  in  1  one-cycle pulse; captures iEXP_VALUE
- oBUSY  out  1  high in every state except DONE
- oDONE  out  1  table completed at least once since reset or restart
- oERR  out  1  sticky; set when any write exhausts MAX_TRY
- oERR_IDX  out  8  index of the most recent failed entry (8'hFF = exposure write)
- oSTATE  out  3  FSM state, for debug

## Operation
- Tick divider: counts 0..CLK_DIV-1 and asserts an internal tick when count = CLK_DIV-1.
- FSM states: LOAD, ISSUE, WAIT, NEXT, DONE, EXP. All transitions happen on tick cycles only.
- LOAD: drive oI2C_DATA from the table entry at oLUT_ADDR; go to ISSUE.
- ISSUE: raise oGO; go to WAIT.
- WAIT, on iEND=1: drop oGO.
  - If iNACK=0: go to NEXT.
  - If iNACK=1: increment the try counter. If the counter has reached MAX_TRY, set oERR, load oERR_IDX, and go to NEXT. Otherwise go to LOAD (retry).
- NEXT: clear the try counter. If oLUT_ADDR = LUT_SIZE-1, set oDONE and go to DONE. Otherwise increment oLUT_ADDR and go to LOAD.
- DONE: iRESTART has priority. A restart clears oLUT_ADDR and oDONE (oERR is kept) and goes to LOAD. Otherwise, if an exposure update is pending, clear the pending flag and go to EXP.
- EXP: frame = `{SLAVE_ADDR, EXP_REG, captured value}`; raise oGO. Share WAIT with the same retry rules (oERR_IDX=8'hFF), then return to DONE instead of NEXT.
- Exposure capture: iEXP_UPDATE is sampled on every iCLK, not only on ticks. It sets the pending flag and stores iEXP_VALUE. Of several pulses before service, the latest value wins. A pulse during the initial table walk or during EXP stays pending and is served from DONE.
- iRESTART outside DONE: ignored.

## Timing
- Reset values:
  - oLUT_ADDR=0, oI2C_DATA=0, oGO=0, oBUSY=1, oDONE=0, oERR=0, oERR_IDX=0, oSTATE=LOAD.
  - Divider=0, try counter=0, pending=0.
- Reset mid-transfer: oGO is 0 at the first edge with iRST high. The FSM restarts at entry 0 after reset deasserts.
- Successful write latency: LOAD→ISSUE→WAIT = 2 ticks to oGO, then WAIT until iEND, then 1 tick in NEXT.
- oI2C_DATA is stable from LOAD until the next LOAD or EXP; it never changes while oGO=1.
- oGO stays high until iEND is sampled high on a tick. iEND arriving between ticks is seen at the next tick.
- Simultaneous iRESTART and a pending exposure in DONE: the table runs first. Pending is kept and is served afterwards with the latest value.

## Configuration
- I2C_CFG_LIVE_EXP_EN defined: exposure capture, the EXP state and the 8'hFF error index are built.
- Not defined: iEXP_UPDATE and iEXP_VALUE are ignored, EXP is never entered, and DONE reacts only to iRESTART.

## Test plan
- Table of 3 entries, responder always ACKs: 3 frames, for example `{BA,09,0123}`, in index order → oDONE=1, oERR=0, oLUT_ADDR=2, oBUSY=0.
- Entry 1 NACKs twice then ACKs, MAX_TRY=3: entry 1 is sent 3 times, oERR stays 0, entry 2 follows.
- Entry 1 always NACKs, MAX_TRY=3: exactly 3 attempts → oERR=1, oERR_IDX=1, entries 2..end still sent, oDONE=1.
- Exposure pulses 0x0200 then 0x0400 during the table walk: after oDONE, exactly one frame `{BA,09,0400}` is sent.
- iRESTART while in DONE, coincident with an iEXP_UPDATE pulse: the full table replays, then one exposure frame is sent; oERR is kept from earlier.
- iRST asserted while oGO=1 mid-table: oGO=0 next edge, all outputs at reset values, sequence restarts at entry 0.

Source files
------------

// File: rtl/i2c_sensor_cfg_seq.sv
// +--------------------------------------------------------------------------+
// | i2c_sensor_cfg_seq                                                       |
// | Walks a sensor register table into an I2C byte engine with NACK retry;   |
// | optional live exposure writes when I2C_CFG_LIVE_EXP_EN is defined.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module i2c_sensor_cfg_seq #(
   parameter int         CLK_DIV    = 2500,
   parameter logic [7:0] SLAVE_ADDR = 8'hBA,
   parameter int         DATA_W     = 16,
   parameter int         LUT_SIZE   = 17,
   parameter int         MAX_TRY    = 3,
   parameter logic [7:0] EXP_REG    = 8'h09
) (
   input  logic                 iCLK,
   input  logic                 iRST,
   output logic [7:0]           oLUT_ADDR,
   input  logic [8+DATA_W-1:0]  iLUT_DATA,
   output logic [16+DATA_W-1:0] oI2C_DATA,
   output logic                 oGO,
   input  logic                 iEND,
   input  logic                 iNACK,
   input  logic                 iRESTART,
   input  logic [DATA_W-1:0]    iEXP_VALUE,
   input  logic                 iEXP_UPDATE,
   output logic                 oBUSY,
   output logic                 oDONE,
   output logic                 oERR,
   output logic [7:0]           oERR_IDX,
   output logic [2:0]           oSTATE
);

   localparam int         DIV_W      = $clog2(CLK_DIV);
   localparam logic [DIV_W-1:0] c_DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [7:0] c_LAST_IDX = 8'(LUT_SIZE - 1);
   localparam logic [3:0] c_MAX_TRY  = 4'(MAX_TRY);

   localparam logic [2:0] c_LOAD  = 3'd0;
   localparam logic [2:0] c_ISSUE = 3'd1;
   localparam logic [2:0] c_WAIT  = 3'd2;
   localparam logic [2:0] c_NEXT  = 3'd3;
   localparam logic [2:0] c_DONE  = 3'd4;
   localparam logic [2:0] c_EXP   = 3'd5;

   logic [2:0]       r_state;
   logic [2:0]       w_nextState;
   logic [DIV_W-1:0] r_tickCnt;
   logic             w_tick;
   logic [3:0]       r_try;
   logic             w_tryExhausted;
   logic             w_lastIdx;
   logic             r_inExp;
   logic             r_restartReq;
   logic             w_restart;
   logic             w_expGo;

   assign w_tick         = (r_tickCnt == c_DIV_LAST);
   assign w_tryExhausted = ((r_try + 4'd1) >= c_MAX_TRY);
   assign w_lastIdx      = (oLUT_ADDR == c_LAST_IDX);
   assign w_restart      = iRESTART | r_restartReq;

   always_ff @(posedge iCLK) begin
      if (iRST || w_tick) begin
         r_tickCnt <= '0;
      end else begin
         r_tickCnt <= r_tickCnt + DIV_W'(1);
      end
   end

   // A restart pulse between ticks is held until the DONE tick that serves it.
   always_ff @(posedge iCLK) begin
      if (iRST || r_state != c_DONE || w_tick) begin
         r_restartReq <= 1'b0;
      end else if (iRESTART) begin
         r_restartReq <= 1'b1;
      end
   end

`ifdef I2C_CFG_LIVE_EXP_EN
   logic              r_expPend;
   logic [DATA_W-1:0] r_expVal;
   logic [DATA_W-1:0] r_expShadow;

   // Shadow copy freezes the value being sent; a newer pulse stays pending.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         r_expPend   <= 1'b0;
         r_expVal    <= '0;
         r_expShadow <= '0;
      end else begin
         if (w_tick && r_state == c_DONE && !w_restart && r_expPend) begin
            r_expPend   <= 1'b0;
            r_expShadow <= r_expVal;
         end
         if (iEXP_UPDATE) begin
            r_expPend <= 1'b1;
            r_expVal  <= iEXP_VALUE;
         end
      end
   end

   assign w_expGo = r_expPend;
`else
   logic w_unusedExp;
   assign w_unusedExp = ^{iEXP_VALUE, iEXP_UPDATE};
   assign w_expGo     = 1'b0;
`endif

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         r_state <= c_LOAD;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      if (w_tick) begin
         case (r_state)
            c_LOAD:  w_nextState = c_ISSUE;
            c_ISSUE: w_nextState = c_WAIT;
            c_WAIT: begin
               if (iEND) begin
                  if (!iNACK || w_tryExhausted) begin
                     w_nextState = r_inExp ? c_DONE : c_NEXT;
                  end else begin
                     w_nextState = r_inExp ? c_EXP : c_LOAD;
                  end
               end
            end
            c_NEXT:  w_nextState = w_lastIdx ? c_DONE : c_LOAD;
            c_DONE: begin
               if (w_restart) begin
                  w_nextState = c_LOAD;
               end else if (w_expGo) begin
                  w_nextState = c_EXP;
               end
            end
            c_EXP:   w_nextState = c_WAIT;
            default: w_nextState = c_LOAD;
         endcase
      end
   end

   always_comb begin
      oBUSY  = (r_state != c_DONE);
      oSTATE = r_state;
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         oLUT_ADDR <= '0;
         oI2C_DATA <= '0;
         oGO       <= 1'b0;
         oDONE     <= 1'b0;
         oERR      <= 1'b0;
         oERR_IDX  <= '0;
         r_try     <= '0;
         r_inExp   <= 1'b0;
      end else if (w_tick) begin
         case (r_state)
            c_LOAD:  oI2C_DATA <= {SLAVE_ADDR, iLUT_DATA};
            c_ISSUE: oGO <= 1'b1;
            c_WAIT: begin
               if (iEND) begin
                  oGO <= 1'b0;
                  if (!iNACK) begin
                     r_try <= '0;
                  end else if (w_tryExhausted) begin
                     r_try    <= '0;
                     oERR     <= 1'b1;
                     oERR_IDX <= r_inExp ? 8'hFF : oLUT_ADDR;
                  end else begin
                     r_try <= r_try + 4'd1;
                  end
                  if (!iNACK || w_tryExhausted) begin
                     r_inExp <= 1'b0;
                  end
               end
            end
            c_NEXT: begin
               r_try <= '0;
               if (w_lastIdx) begin
                  oDONE <= 1'b1;
               end else begin
                  oLUT_ADDR <= oLUT_ADDR + 8'd1;
               end
            end
            c_DONE: begin
               if (w_restart) begin
                  oLUT_ADDR <= '0;
                  oDONE     <= 1'b0;
               end else if (w_expGo) begin
                  r_inExp <= 1'b1;
               end
            end
`ifdef I2C_CFG_LIVE_EXP_EN
            c_EXP: begin
               oI2C_DATA <= {SLAVE_ADDR, EXP_REG, r_expShadow};
               oGO       <= 1'b1;
            end
`endif
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_i2c_sensor_cfg_seq.sv
// +--------------------------------------------------------------------------+
// | tb_i2c_sensor_cfg_seq                                                    |
// | Self-checking bench: table vectors, random scenarios, scripted responder.|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_i2c_sensor_cfg_seq;

   localparam int         CLK_DIV  = 3;
   localparam logic [7:0] SLAVE    = 8'hBA;
   localparam int         DATA_W   = 16;
   localparam int         LUT_SIZE = 3;
   localparam int         MAX_TRY  = 3;
   localparam logic [7:0] EXP_REG  = 8'h09;

   logic        clk = 1'b0;
   logic        iRST;
   logic [7:0]  oLUT_ADDR;
   logic [23:0] iLUT_DATA;
   logic [31:0] oI2C_DATA;
   logic        oGO, iEND, iNACK, iRESTART, iEXP_UPDATE;
   logic [15:0] iEXP_VALUE;
   logic        oBUSY, oDONE, oERR;
   logic [7:0]  oERR_IDX;
   logic [2:0]  oSTATE;

   always #5 clk = ~clk;

   i2c_sensor_cfg_seq #(
      .CLK_DIV(CLK_DIV), .SLAVE_ADDR(SLAVE), .DATA_W(DATA_W),
      .LUT_SIZE(LUT_SIZE), .MAX_TRY(MAX_TRY), .EXP_REG(EXP_REG)
   ) dut (
      .iCLK(clk), .iRST(iRST), .oLUT_ADDR(oLUT_ADDR), .iLUT_DATA(iLUT_DATA),
      .oI2C_DATA(oI2C_DATA), .oGO(oGO), .iEND(iEND), .iNACK(iNACK),
      .iRESTART(iRESTART), .iEXP_VALUE(iEXP_VALUE), .iEXP_UPDATE(iEXP_UPDATE),
      .oBUSY(oBUSY), .oDONE(oDONE), .oERR(oERR), .oERR_IDX(oERR_IDX), .oSTATE(oSTATE)
   );

   logic [23:0] lut [3];
   assign iLUT_DATA = (oLUT_ADDR < 8'd3) ? lut[oLUT_ADDR[1:0]] : 24'h0;

   int checks = 0;
   int failures = 0;
   logic [31:0] expQ[$];
   logic [31:0] obsQ[$];
   logic        respQ[$];
   logic        mErr;
   logic [7:0]  mIdx;
   int          stabErr = 0;

   typedef struct {
      int         n0, n1, n2;
      logic       expErr;
      logic [7:0] expIdx;
      int         expFrames;
   } vec_t;
   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Responder: records each frame, answers with the next scripted NACK bit.
   initial begin
      logic nack;
      iEND = 1'b0;
      iNACK = 1'b0;
      forever begin
         @(negedge clk);
         if (oGO && !iRST) begin
            obsQ.push_back(oI2C_DATA);
            nack = (respQ.size() > 0) ? respQ.pop_front() : 1'b0;
            repeat ($urandom_range(0, 6)) @(negedge clk);
            iNACK = nack;
            iEND  = 1'b1;
            for (int w = 0; w < 200 && oGO; w++) @(negedge clk);
            iEND  = 1'b0;
            iNACK = 1'b0;
         end
      end
   end

   initial begin
      logic        pGo = 1'b0;
      logic [31:0] pData = 32'h0;
      forever begin
         @(negedge clk);
         if (pGo && oGO && oI2C_DATA !== pData) stabErr++;
         pGo   = oGO;
         pData = oI2C_DATA;
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   // Reference model: each entry is sent until ACK or MAX_TRY attempts.
   task automatic planTable(input int n0, input int n1, input int n2);
      int nk[3];
      nk = '{n0, n1, n2};
      for (int i = 0; i < 3; i++) begin
         int att;
         att = (nk[i] >= MAX_TRY) ? MAX_TRY : nk[i] + 1;
         for (int a = 0; a < att; a++) begin
            expQ.push_back({SLAVE, lut[i]});
            respQ.push_back(a < nk[i]);
         end
         if (nk[i] >= MAX_TRY) begin
            mErr = 1'b1;
            mIdx = 8'(i);
         end
      end
   endtask

   task automatic planExp(input logic [15:0] val, input int nk);
      int att;
      att = (nk >= MAX_TRY) ? MAX_TRY : nk + 1;
      for (int a = 0; a < att; a++) begin
         expQ.push_back({SLAVE, EXP_REG, val});
         respQ.push_back(a < nk);
      end
      if (nk >= MAX_TRY) begin
         mErr = 1'b1;
         mIdx = 8'hFF;
      end
   endtask

   task automatic doReset();
      iRST = 1'b1;
      repeat (12) @(negedge clk);
      obsQ.delete();
      expQ.delete();
      respQ.delete();
      mErr = 1'b0;
      mIdx = 8'h00;
      iRST = 1'b0;
   endtask

   task automatic waitIdle(input string name);
      int run = 0;
      int n = 0;
      while (run < 4 * CLK_DIV && n < 5000) begin
         @(negedge clk);
         n++;
         if (oDONE && !oBUSY && !oGO) run++;
         else run = 0;
      end
      chk({name, "_idle_reached"}, 32'(n < 5000), 1);
   endtask

   task automatic checkFrames(input string name);
      chk({name, "_nframes"}, obsQ.size(), expQ.size());
      for (int i = 0; i < expQ.size() && i < obsQ.size(); i++)
         chk($sformatf("%s_frame%0d", name, i), obsQ[i], expQ[i]);
      obsQ.delete();
      expQ.delete();
      respQ.delete();
   endtask

   task automatic checkEnd(input string name);
      chk({name, "_done"}, 32'(oDONE), 1);
      chk({name, "_busy"}, 32'(oBUSY), 0);
      chk({name, "_addr"}, 32'(oLUT_ADDR), 2);
      chk({name, "_err"}, 32'(oERR), 32'(mErr));
      chk({name, "_erridx"}, 32'(oERR_IDX), 32'(mIdx));
   endtask

   task automatic pulseExp(input logic [15:0] val);
      iEXP_VALUE  = val;
      iEXP_UPDATE = 1'b1;
      @(negedge clk);
      iEXP_UPDATE = 1'b0;
   endtask

   task automatic pulseRestart();
      iRESTART = 1'b1;
      @(negedge clk);
      iRESTART = 1'b0;
   endtask

   task automatic waitGo(input string name, input logic onEntry1);
      int n = 0;
      while (!(oGO && (!onEntry1 || oLUT_ADDR == 8'd1)) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_go_seen"}, 32'(n < 3000), 1);
   endtask

   initial begin
      int nObs;
      iRESTART = 1'b0;
      iEXP_UPDATE = 1'b0;
      iEXP_VALUE = 16'h0;
      mErr = 1'b0;
      mIdx = 8'h00;
      lut[0] = {8'h09, 16'h0123};
      lut[1] = {8'h0A, 16'h4567};
      lut[2] = {8'h20, 16'hBEEF};

      vecs[0] = '{0, 0, 0, 1'b0, 8'h00, 3};
      vecs[1] = '{0, 2, 0, 1'b0, 8'h00, 5};
      vecs[2] = '{0, 9, 0, 1'b1, 8'h01, 5};
      vecs[3] = '{1, 0, 3, 1'b1, 8'h02, 6};
      vecs[4] = '{3, 3, 0, 1'b1, 8'h01, 7};
      vecs[5] = '{2, 2, 2, 1'b0, 8'h00, 9};

      // Reset values while reset is held
      iRST = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_addr", 32'(oLUT_ADDR), 0);
      chk("rst_data", oI2C_DATA, 0);
      chk("rst_go", 32'(oGO), 0);
      chk("rst_busy", 32'(oBUSY), 1);
      chk("rst_done", 32'(oDONE), 0);
      chk("rst_err", 32'(oERR), 0);
      chk("rst_erridx", 32'(oERR_IDX), 0);

      for (int v = 0; v < 6; v++) begin
         doReset();
         planTable(vecs[v].n0, vecs[v].n1, vecs[v].n2);
         waitIdle($sformatf("vec%0d", v));
         chk($sformatf("vec%0d_hand_nframes", v), obsQ.size(), vecs[v].expFrames);
         chk($sformatf("vec%0d_hand_err", v), 32'(oERR), 32'(vecs[v].expErr));
         chk($sformatf("vec%0d_hand_erridx", v), 32'(oERR_IDX), 32'(vecs[v].expIdx));
         checkEnd($sformatf("vec%0d", v));
         checkFrames($sformatf("vec%0d", v));
      end

      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 3; i++) lut[i] = 24'($urandom);
         doReset();
         planTable($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4));
         waitIdle($sformatf("rnd%0d", r));
         checkEnd($sformatf("rnd%0d", r));
         checkFrames($sformatf("rnd%0d", r));
      end
      lut[0] = {8'h09, 16'h0123};
      lut[1] = {8'h0A, 16'h4567};
      lut[2] = {8'h20, 16'hBEEF};

      // Restart outside DONE is ignored
      doReset();
      planTable(0, 0, 0);
      repeat (20) @(negedge clk);
      pulseRestart();
      waitIdle("rstrt_walk");
      checkEnd("rstrt_walk");
      checkFrames("rstrt_walk");

      // Error run, then restart; reset while GO is high on entry 1
      doReset();
      planTable(0, 9, 0);
      waitIdle("midrst_pre");
      checkEnd("midrst_pre");
      checkFrames("midrst_pre");
      pulseRestart();
      waitGo("midrst", 1'b1);
      iRST = 1'b1;
      @(negedge clk);
      chk("midrst_go", 32'(oGO), 0);
      chk("midrst_addr", 32'(oLUT_ADDR), 0);
      chk("midrst_data", oI2C_DATA, 0);
      chk("midrst_busy", 32'(oBUSY), 1);
      chk("midrst_done", 32'(oDONE), 0);
      chk("midrst_err", 32'(oERR), 0);
      chk("midrst_erridx", 32'(oERR_IDX), 0);
      doReset();
      planTable(0, 0, 0);
      waitIdle("midrst_post");
      checkEnd("midrst_post");
      checkFrames("midrst_post");

`ifdef I2C_CFG_LIVE_EXP_EN
      // Two exposure pulses during the walk: only the latest is sent, once
      doReset();
      planTable(0, 0, 0);
      planExp(16'h0400, 0);
      repeat (5) @(negedge clk);
      pulseExp(16'h0200);
      repeat (4) @(negedge clk);
      pulseExp(16'h0400);
      waitIdle("exp_walk");
      checkEnd("exp_walk");
      checkFrames("exp_walk");

      // Restart coincident with exposure update; oERR survives restart
      doReset();
      planTable(0, 9, 0);
      waitIdle("exp_rst_pre");
      checkEnd("exp_rst_pre");
      checkFrames("exp_rst_pre");
      planTable(0, 0, 0);
      planExp(16'h0777, 0);
      iRESTART = 1'b1;
      iEXP_VALUE = 16'h0777;
      iEXP_UPDATE = 1'b1;
      @(negedge clk);
      iRESTART = 1'b0;
      iEXP_UPDATE = 1'b0;
      waitGo("exp_rst", 1'b0);
      chk("exp_rst_done_cleared", 32'(oDONE), 0);
      waitIdle("exp_rst");
      checkEnd("exp_rst");
      checkFrames("exp_rst");

      // Exposure writes from DONE, random values and NACK counts
      doReset();
      planTable(0, 0, 0);
      waitIdle("exp_rnd_pre");
      checkFrames("exp_rnd_pre");
      for (int r = 0; r < 5; r++) begin
         logic [15:0] val;
         val = 16'($urandom);
         planExp(val, (r == 0) ? 5 : int'($urandom_range(0, 3)));
         pulseExp(val);
         waitIdle($sformatf("exp_rnd%0d", r));
         checkEnd($sformatf("exp_rnd%0d", r));
         checkFrames($sformatf("exp_rnd%0d", r));
      end
`else
      // Exposure inputs have no effect in this build
      doReset();
      planTable(0, 0, 0);
      waitIdle("noexp_pre");
      checkFrames("noexp_pre");
      pulseExp(16'h0400);
      repeat (20 * CLK_DIV) @(negedge clk);
      nObs = obsQ.size();
      chk("noexp_nframes", nObs, 0);
      chk("noexp_busy", 32'(oBUSY), 0);
      obsQ.delete();
`endif

      chk("frame_stable_under_go", stabErr, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
